w4823_fir_seq: RTL and testbench

Tap sequencer and coefficient-port arbiter for the W4823 FP16 FIR. Runs on the fast clock and time-multiplexes one shared FP16 MAC over a 64-entry circular delay line, producing one filtered sample per accepted input. Also owns the coefficient RAM write port: host coefficient loads are granted only between samples, never during a tap sweep.

---
 rtl/w4823_fir_pkg.sv | 17 +
 rtl/w4823_fir_tapgen.sv | 60 ++++++
 rtl/w4823_fir_seq.sv | 105 ++++++++++
 tb/tb_w4823_fir_seq.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/w4823_fir_pkg.sv
// Shared types and defaults for the W4823 FP16 FIR tap sequencer.
package w4823_fir_pkg;

  localparam int NTAPS_DEF   = 64;
  localparam int AW_DEF      = 6;
  localparam int MAC_LAT_DEF = 3;
  localparam int CW          = 17;  // coefficient word width

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WRITE = 3'd1,
    RUN   = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/w4823_fir_tapgen.sv
// Tap counter plus registered delay-line / coefficient address generation.
// W4823_FIR_SEQ_SYM_EN folds the coefficient address for symmetric filters.
module w4823_fir_tapgen #(
  parameter int NTAPS = 64,
  parameter int AW    = 6
) (
  input  logic          clk2,
  input  logic          rst,
  input  logic          load,      // WRITE cycle: next cycle is tap 0
  input  logic          run,       // RUN cycle
  input  logic [AW-1:0] wptr,
  output logic          last,      // current tap is NTAPS-1
  output logic [AW-1:0] crd_addr,
  output logic [AW-1:0] drd_addr,
  output logic          mac_en,
  output logic          mac_first,
  output logic          mac_last
);

  logic [AW-1:0] k, k_nxt, crd_nxt;
  logic          issue;

  assign last  = (k == AW'(NTAPS-1));
  assign issue = load | (run & ~last);
  assign k_nxt = load ? '0 : k + 1'b1;

`ifdef W4823_FIR_SEQ_SYM_EN
  // second half of the sweep walks the stored half back down
  assign crd_nxt = (k_nxt < AW'(NTAPS/2)) ? k_nxt : AW'(NTAPS-1) - k_nxt;
`else
  assign crd_nxt = k_nxt;
`endif

  // Strobes and addresses are computed for the tap about to be shown, so
  // they leave this block straight from flops.
  always_ff @(posedge clk2) begin
    if (rst) begin
      k         <= '0;
      crd_addr  <= '0;
      drd_addr  <= '0;
      mac_en    <= 1'b0;
      mac_first <= 1'b0;
      mac_last  <= 1'b0;
    end else if (issue) begin
      k         <= k_nxt;
      crd_addr  <= crd_nxt;
      drd_addr  <= wptr - k_nxt;  // wraps modulo NTAPS through AW bits
      mac_en    <= 1'b1;
      mac_first <= (k_nxt == '0);
      mac_last  <= (k_nxt == AW'(NTAPS-1));
    end else begin
      crd_addr  <= '0;
      drd_addr  <= '0;
      mac_en    <= 1'b0;
      mac_first <= 1'b0;
      mac_last  <= 1'b0;
    end
  end

endmodule

// File: rtl/w4823_fir_seq.sv
// W4823 FIR tap sequencer and coefficient-port arbiter. One sample per
// accepted input; coefficient loads only granted in IDLE, ahead of samples.
// W4823_FIR_SEQ_SYM_EN: only the lower NTAPS/2 coefficients are writable.
module w4823_fir_seq
  import w4823_fir_pkg::*;
#(
  parameter int NTAPS   = NTAPS_DEF,
  parameter int AW      = AW_DEF,
  parameter int MAC_LAT = MAC_LAT_DEF
) (
  input  logic          clk2,
  input  logic          rst,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic          cload,
  input  logic [AW-1:0] caddr,
  input  logic [CW-1:0] cin,
  output logic          cack,
  output logic          cwr_en,
  output logic [AW-1:0] cwr_addr,
  output logic [CW-1:0] cwr_data,
  output logic [AW-1:0] crd_addr,
  output logic          dwr_en,
  output logic [AW-1:0] dwr_addr,
  output logic [AW-1:0] drd_addr,
  output logic          mac_en,
  output logic          mac_first,
  output logic          mac_last,
  output logic          out_valid,
  output logic          busy
);

  localparam int DW = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;

  state_t        state, state_nxt;
  logic [AW-1:0] wptr;
  logic [DW-1:0] dcnt;
  logic          idle, accept, last, drain_end, cwr_ok;

  assign idle      = (state == IDLE);
  assign accept    = idle & s_valid & ~cload;
  assign drain_end = (state == DRAIN) & (dcnt == DW'(MAC_LAT-1));

`ifdef W4823_FIR_SEQ_SYM_EN
  assign cwr_ok = (caddr < AW'(NTAPS/2));
`else
  assign cwr_ok = 1'b1;
`endif

  // Coefficient port is a pass-through gated only by the registered state.
  assign s_ready  = idle & ~cload;
  assign cack     = idle & cload;
  assign cwr_en   = cack & cwr_ok;
  assign cwr_addr = cack ? caddr : '0;
  assign cwr_data = cack ? cin   : '0;

  // Next-state sweep: IDLE -> WRITE -> RUN x NTAPS -> DRAIN x MAC_LAT -> DONE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = WRITE;
      WRITE:   state_nxt = RUN;
      RUN:     if (last) state_nxt = DRAIN;
      DRAIN:   if (drain_end) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State, write pointer, drain counter and registered write/done strobes.
  always_ff @(posedge clk2) begin
    if (rst) begin
      state     <= IDLE;
      wptr      <= '0;
      dcnt      <= '0;
      dwr_en    <= 1'b0;
      dwr_addr  <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      dcnt      <= (state == DRAIN) ? dcnt + 1'b1 : '0;
      if (state == DONE) wptr <= wptr + 1'b1;
      dwr_en    <= accept;
      dwr_addr  <= accept ? wptr : '0;
      out_valid <= drain_end;
      busy      <= (state_nxt != IDLE);
    end
  end

  w4823_fir_tapgen #(.NTAPS(NTAPS), .AW(AW)) u_tapgen (
    .clk2      (clk2),
    .rst       (rst),
    .load      (state == WRITE),
    .run       (state == RUN),
    .wptr      (wptr),
    .last      (last),
    .crd_addr  (crd_addr),
    .drd_addr  (drd_addr),
    .mac_en    (mac_en),
    .mac_first (mac_first),
    .mac_last  (mac_last)
  );

endmodule

// File: tb/tb_w4823_fir_seq.sv
// Self-checking bench for w4823_fir_seq. A phase-based reference model
// (cycles since sample accept) predicts every output every cycle.
module tb_w4823_fir_seq;

  localparam int NT = 64;
  localparam int ML = 3;
`ifdef W4823_FIR_SEQ_SYM_EN
  localparam bit SYM = 1'b1;
`else
  localparam bit SYM = 1'b0;
`endif

  logic        clk2, rst, s_valid, s_ready, cload, cack, cwr_en, dwr_en;
  logic        mac_en, mac_first, mac_last, out_valid, busy;
  logic [5:0]  caddr, cwr_addr, crd_addr, dwr_addr, drd_addr;
  logic [16:0] cin, cwr_data;

  w4823_fir_seq #(.NTAPS(NT), .AW(6), .MAC_LAT(ML)) dut (
    .clk2(clk2), .rst(rst), .s_valid(s_valid), .s_ready(s_ready),
    .cload(cload), .caddr(caddr), .cin(cin), .cack(cack),
    .cwr_en(cwr_en), .cwr_addr(cwr_addr), .cwr_data(cwr_data),
    .crd_addr(crd_addr), .dwr_en(dwr_en), .dwr_addr(dwr_addr),
    .drd_addr(drd_addr), .mac_en(mac_en), .mac_first(mac_first),
    .mac_last(mac_last), .out_valid(out_valid), .busy(busy)
  );

  initial clk2 = 1'b0;
  always #5 clk2 = ~clk2;

  int checks = 0, errors = 0;
  int t;              // -1 idle, else cycles since the accept edge
  logic [5:0] mw;     // model write pointer

  // captured outputs of the most recent sampled cycle
  logic c_sr, c_ck, c_cwe, c_dwe, c_mac, c_mf, c_ml, c_ov, c_busy;
  logic [5:0] c_cwa, c_dwa, c_drd;
  logic [16:0] c_cwd;

  typedef struct {
    logic cl; logic [5:0] ca; logic [16:0] cd; logic sv;
    logic e_sr; logic e_ck; logic e_cw;
  } vec_t;
  vec_t tbl[6];

  function automatic logic [49:0] model_out();
    logic s_r, ck, cw, de, me, mf, ml, ov, bz;
    logic [5:0] ca, cr, da, dr;
    logic [16:0] cd;
    int k;
    {s_r, ck, cw, de, me, mf, ml, ov, bz} = '0;
    ca = '0; cr = '0; da = '0; dr = '0; cd = '0;
    if (t < 0) begin
      s_r = !cload;
      ck  = cload;
      cw  = cload && (!SYM || caddr < 6'd32);
      ca  = cload ? caddr : 6'd0;
      cd  = cload ? cin : 17'd0;
    end else begin
      bz = 1'b1;
      if (t == 1) begin de = 1'b1; da = mw; end
      if (t >= 2 && t <= NT + 1) begin
        k  = t - 2;
        me = 1'b1;
        mf = (k == 0);
        ml = (k == NT - 1);
        cr = (SYM && k >= NT / 2) ? 6'(NT - 1 - k) : 6'(k);
        dr = 6'((int'(mw) - k + NT) % NT);
      end
      if (t == NT + ML + 2) ov = 1'b1;
    end
    return {s_r, ck, cw, ca, cd, cr, de, da, dr, me, mf, ml, ov, bz};
  endfunction

  task automatic step(input string nm);
    logic [49:0] act, exp;
    @(negedge clk2);
    act = {s_ready, cack, cwr_en, cwr_addr, cwr_data, crd_addr, dwr_en,
           dwr_addr, drd_addr, mac_en, mac_first, mac_last, out_valid, busy};
    exp = model_out();
    {c_sr, c_ck, c_cwe, c_cwa, c_cwd} = act[49:24];
    {c_dwe, c_dwa, c_drd, c_mac, c_mf, c_ml, c_ov, c_busy} = act[17:0];
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0d wptr=%0d outputs got %h want %h", nm, t, mw, act, exp);
    end
    @(posedge clk2);
    if (rst) begin t = -1; mw = '0; end
    else if (t < 0) begin if (s_valid && !cload) t = 1; end
    else if (t == NT + ML + 2) begin t = -1; mw = mw + 1'b1; end
    else t++;
    #1;
  endtask

  task automatic chk(input string nm, input int a, input int e);
    checks++;
    if (a != e) begin
      errors++;
      $display("FAIL %s got %0d want %0d", nm, a, e);
    end
  endtask

  task automatic run_sample(output int ov, output int fc, output int lc, output int da);
    ov = -1; fc = -1; lc = -1; da = -1;
    s_valid = 1'b1;
    step("accept");
    chk("accept_ready", int'(c_sr), 1);
    s_valid = 1'b0;
    for (int c = 1; c <= 150; c++) begin
      step("sample");
      if (c == 1 && c_dwe) da = int'(c_dwa);
      if (c_mf && fc < 0) fc = c;
      if (c_ml) lc = c;
      if (c_ov) begin ov = c; break; end
    end
    if (ov < 0) begin
      checks++; errors++;
      $display("FAIL out_valid_timeout got none want pulse");
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 100 && t >= 0; i++) step("drain_idle");
  endtask

  initial begin
    int ov, fc, lc, da, cyc, nov;
    rst = 1'b1; s_valid = 1'b0; cload = 1'b0; caddr = '0; cin = '0;
    t = -1; mw = '0;
    repeat (2) @(posedge clk2);
    #1;
    step("reset");
    chk("reset_busy", int'(c_busy), 0);
    chk("reset_sready", int'(c_sr), 1);
    rst = 1'b0;
    step("post_reset");

    // IDLE coefficient-port pass-through table
    tbl[0] = '{1'b0, 6'd0,  17'h00000, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 6'd5,  17'h1ABCD, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[2] = '{1'b1, 6'd40, 17'h0F0F0, 1'b0, 1'b0, 1'b1, !SYM};
    tbl[3] = '{1'b1, 6'd63, 17'h1FFFF, 1'b1, 1'b0, 1'b1, !SYM};
    tbl[4] = '{1'b1, 6'd31, 17'h00001, 1'b1, 1'b0, 1'b1, 1'b1};
    tbl[5] = '{1'b1, 6'd32, 17'h12345, 1'b0, 1'b0, 1'b1, !SYM};
    for (int i = 0; i < 6; i++) begin
      cload = tbl[i].cl; caddr = tbl[i].ca; cin = tbl[i].cd; s_valid = tbl[i].sv;
      step("tbl_vec");
      chk("tbl_sready", int'(c_sr), int'(tbl[i].e_sr));
      chk("tbl_cack", int'(c_ck), int'(tbl[i].e_ck));
      chk("tbl_cwr_en", int'(c_cwe), int'(tbl[i].e_cw));
      chk("tbl_cwr_addr", int'(c_cwa), tbl[i].e_ck ? int'(tbl[i].ca) : 0);
      chk("tbl_cwr_data", int'(c_cwd), tbl[i].e_ck ? int'(tbl[i].cd) : 0);
    end
    cload = 1'b0; s_valid = 1'b0; caddr = '0; cin = '0;
    step("tbl_done");

    // single sample latency from reset
    run_sample(ov, fc, lc, da);
    chk("first_dwr_addr", da, 0);
    chk("first_mac_first_cyc", fc, 2);
    chk("first_mac_last_cyc", lc, 65);
    chk("first_out_valid_cyc", ov, 69);
    run_sample(ov, fc, lc, da);
    chk("second_dwr_addr", da, 1);
    chk("second_out_valid_cyc", ov, 69);

    // coefficient load held through a sweep is granted only in IDLE
    s_valid = 1'b1;
    step("cl_accept");
    s_valid = 1'b0;
    for (int c = 1; c <= 9; c++) step("cl_run");
    cload = 1'b1; caddr = 6'd5; cin = 17'h1ABCD;
    cyc = -1;
    for (int c = 10; c <= 150; c++) begin
      step("cl_wait");
      if (c_ck) begin
        cyc = c;
        chk("cl_cwr_en", int'(c_cwe), 1);
        chk("cl_cwr_addr", int'(c_cwa), 5);
        chk("cl_cwr_data", int'(c_cwd), 'h1ABCD);
        cload = 1'b0;
        break;
      end
    end
    chk("cl_cack_cycle", cyc, 70);
    step("cl_drop");
    chk("cl_cack_once", int'(c_ck), 0);

    // simultaneous s_valid and cload: write first, sample next cycle
    s_valid = 1'b1; cload = 1'b1; caddr = 6'd7; cin = 17'h00003;
    step("both");
    chk("both_cack", int'(c_ck), 1);
    chk("both_sready", int'(c_sr), 0);
    cload = 1'b0;
    step("both_accept");
    chk("both_accept_ready", int'(c_sr), 1);
    s_valid = 1'b0;
    step("both_write");
    chk("both_dwr_en", int'(c_dwe), 1);
    wait_idle();

    // 65 back-to-back samples: pointer wrap and modulo read address
    s_valid = 1'b1; nov = 0;
    for (int c = 0; c < 65 * 70 + 100 && nov < 65; c++) begin
      int tt;
      logic [5:0] mm;
      tt = t; mm = mw;
      step("b2b");
      if (c_ov) nov++;
      if (tt == 7 && mm == 6'd2) chk("b2b_drd_wrap", int'(c_drd), 61);
      if (tt == 1 && mm == 6'd0) chk("b2b_wptr_wrap", int'(c_dwa), 0);
    end
    chk("b2b_count", nov, 65);
    s_valid = 1'b0;
    wait_idle();

    // reset at RUN tap 30
    s_valid = 1'b1;
    step("rst_accept");
    s_valid = 1'b0;
    for (int c = 1; c <= 31; c++) step("rst_run");
    rst = 1'b1;
    step("rst_tap30");
    rst = 1'b0;
    step("rst_after");
    chk("rst_busy", int'(c_busy), 0);
    chk("rst_mac_en", int'(c_mac), 0);
    chk("rst_out_valid", int'(c_ov), 0);
    repeat (80) step("rst_quiet");
    run_sample(ov, fc, lc, da);
    chk("rst_fresh_dwr_addr", da, 0);
    chk("rst_fresh_out_valid_cyc", ov, 69);

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      s_valid = ($urandom_range(0, 3) == 0);
      cload   = ($urandom_range(0, 7) == 0);
      caddr   = 6'($urandom);
      cin     = 17'($urandom);
      step("rand");
    end
    s_valid = 1'b0; cload = 1'b0;
    wait_idle();
    step("final_idle");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
